// File: rtl/pipe_mem_arbiter_if.sv
// pipe_mem_arbiter_if: IF/MEM request buses plus the unified memory port
// slave  : arbiter side (takes requests, drives done/rdata/stalls and the memory port)
// master : pipeline + memory model side
interface pipe_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_done, i_rdata, d_done, d_rdata, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_done, i_rdata, d_done, d_rdata, stall_if, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter: shares one memory port between IF fetch and MEM lw/sw with fixed-latency accesses
// clock, reset : rising-edge clock, synchronous active-high reset
// bus.i_*      : fetch request / one-cycle done / registered instruction
// bus.d_*      : load-store request / one-cycle done / registered load data
// bus.stall_*  : combinational freeze levels while a request is outstanding
// bus.mem_*    : memory port, held stable for all LAT busy cycles
module pipe_mem_arbiter #(
  parameter int LAT = 2
) (
  input logic clock,
  input logic reset,
  pipe_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, last_q, last_d, we_q, we_d, pick_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  // alternating priority on a tie: D wins when the last access belonged to I
  assign pick_d = bus.d_req & (~bus.i_req | ~last_q);
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (state_q == IDLE && (bus.i_req | bus.d_req)) begin
      state_d = BUSY;
      owner_d = pick_d;
      cnt_d   = 4'(LAT - 1);
      addr_d  = pick_d ? bus.d_addr : bus.i_addr;
      we_d    = pick_d & bus.d_we;
      wdata_d = pick_d ? bus.d_wdata : 32'h0;
    end else if (state_q == BUSY && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else if (state_q == BUSY) begin
      state_d   = DONE;
      last_d    = owner_q;
      i_rdata_d = (~we_q & ~owner_q) ? bus.mem_rdata : i_rdata_q;
      d_rdata_d = (~we_q & owner_q) ? bus.mem_rdata : d_rdata_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    bus.mem_en    = state_q == BUSY;
    bus.mem_we    = (state_q == BUSY) & we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.i_done    = (state_q == DONE) & ~owner_q;
    bus.d_done    = (state_q == DONE) & owner_q;
    bus.i_rdata   = i_rdata_q;
    bus.d_rdata   = d_rdata_q;
    bus.stall_if  = bus.i_req & ~((state_q == DONE) & ~owner_q);
    bus.stall_mem = bus.d_req & ~((state_q == DONE) & owner_q);
  end
endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// tb_pipe_mem_arbiter: randomized and directed checks of pipe_mem_arbiter against a transaction-level model
module tb_pipe_mem_arbiter;
  localparam int L = 2;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  pipe_mem_arbiter_if a ();
  pipe_mem_arbiter_if b ();
  pipe_mem_arbiter #(.LAT(L)) dut  (.clock(clock), .reset(reset), .bus(a));
  pipe_mem_arbiter #(.LAT(1)) dut1 (.clock(clock), .reset(reset), .bus(b));
  logic [31:0] tb_mem    [0:255];
  logic [31:0] model_mem [0:255];
  int checks = 0;
  int failures = 0;
  assign a.mem_rdata = a.mem_en ? tb_mem[a.mem_addr[9:2]] : 32'hBAD0_BAD0;
  assign b.mem_rdata = b.mem_en ? tb_mem[b.mem_addr[9:2]] : 32'hBAD0_BAD0;
  always @(posedge clock)
    if (!reset && a.mem_en && a.mem_we) tb_mem[a.mem_addr[9:2]] <= a.mem_wdata;
  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = $urandom;
      tb_mem[i]    <= v;
      model_mem[i]  = v;
    end
    tb_mem[1]     <= 32'h8C22_0000;
    model_mem[1]   = 32'h8C22_0000;
    tb_mem[8]     <= 32'h1234_5678;
    model_mem[8]   = 32'h1234_5678;
    tb_mem[16]    <= 32'hA5A5_0040;
    model_mem[16]  = 32'hA5A5_0040;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic chkb(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b", nm, act, exp);
    end
  endtask
  // Model: an access is described by its owner, latched fields and the number of
  // cycles elapsed since the grant edge; phases 1..L are busy, L+1 is the done cycle.
  bit          live = 0;
  bit          m_act = 0;
  bit          m_own = 0;
  bit          m_last = 0;
  bit          m_we = 0;
  bit          m_post_rst = 0;
  int          m_ph = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_ir = '0;
  logic [31:0] m_dr = '0;
  always @(negedge clock) begin
    logic busy, don;
    busy = m_act && m_ph >= 1 && m_ph <= L;
    don  = m_act && m_ph == L + 1;
    if (live) begin
      chkb("mem_en", a.mem_en, busy);
      chkb("mem_we", a.mem_we, busy && m_we);
      if (busy) chk("mem_addr", a.mem_addr, m_addr);
      if (busy && m_we) chk("mem_wdata", a.mem_wdata, m_wd);
      if (m_post_rst) chk("rst_mem_addr", a.mem_addr, 32'h0);
      if (m_post_rst) chk("rst_mem_wdata", a.mem_wdata, 32'h0);
      chkb("i_done", a.i_done, don && !m_own);
      chkb("d_done", a.d_done, don && m_own);
      chk("i_rdata", a.i_rdata, m_ir);
      chk("d_rdata", a.d_rdata, m_dr);
      chkb("stall_if", a.stall_if, a.i_req & ~(don && !m_own));
      chkb("stall_mem", a.stall_mem, a.d_req & ~(don && m_own));
    end
    if (reset) begin
      live = 1;
      m_act = 0;
      m_last = 0;
      m_ir = '0;
      m_dr = '0;
      m_post_rst = 1;
    end else begin
      m_post_rst = 0;
      if (m_act) begin
        if (m_ph == L + 1) m_act = 0;
        else begin
          m_ph++;
          if (m_ph == L + 1) begin
            if (m_we) model_mem[m_addr[9:2]] = m_wd;
            else if (m_own) m_dr = model_mem[m_addr[9:2]];
            else m_ir = model_mem[m_addr[9:2]];
            m_last = m_own;
          end
        end
      end else if (a.i_req || a.d_req) begin
        m_own  = a.d_req && (!a.i_req || !m_last);
        m_addr = m_own ? a.d_addr : a.i_addr;
        m_we   = m_own && a.d_we;
        m_wd   = m_own ? a.d_wdata : 32'h0;
        m_act  = 1;
        m_ph   = 1;
      end
    end
  end
  function automatic logic [31:0] rnd_addr();
    return {22'h0, 8'($urandom), 2'b00};
  endfunction
  task automatic wait_done(input bit d, input bit poke, output int n, output int en,
                           output int wen, output logic [31:0] fa, output logic [31:0] fw,
                           output int bad);
    bit done = 0;
    n = 0; en = 0; wen = 0; bad = 0; fa = '0; fw = '0;
    while (!done && n < 40) begin
      @(posedge clock); #1;
      n++;
      if (a.mem_en) begin
        if (en == 0) begin
          fa = a.mem_addr;
          fw = a.mem_wdata;
        end else if (a.mem_addr !== fa || a.mem_wdata !== fw) bad++;
        en++;
        if (a.mem_we) wen++;
      end
      done = d ? a.d_done : a.i_done;
      if (!done && !(d ? a.stall_mem : a.stall_if)) bad++;
      if (poke && n == 1) a.d_addr = 32'h44;
    end
    chkb("done_within_budget", done, 1'b1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, en, wen, bad, k, t;
    int own [4];
    int at [4];
    logic [31:0] fa, fw;
    bit i_fin, d_fin;
    a.i_req = 0; a.i_addr = '0; a.d_req = 0; a.d_we = 0; a.d_addr = '0; a.d_wdata = '0;
    b.i_req = 0; b.i_addr = '0; b.d_req = 0; b.d_we = 0; b.d_addr = '0; b.d_wdata = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    a.i_req = 1; a.i_addr = 32'h4;
    wait_done(0, 0, n, en, wen, fa, fw, bad);
    chk("if_done_cycle", n, 3);
    chk("if_busy_cycles", en, 2);
    chk("if_we_cycles", wen, 0);
    chk("if_addr", fa, 32'h4);
    chk("if_stall_or_stability", bad, 0);
    chk("if_rdata", a.i_rdata, 32'h8C22_0000);
    chkb("if_stall_at_done", a.stall_if, 1'b0);
    a.i_req = 0;
    @(posedge clock); #1;
    a.d_req = 1; a.d_we = 0; a.d_addr = 32'h40;
    wait_done(1, 1, n, en, wen, fa, fw, bad);
    chk("ld_busy_cycles", en, 2);
    chk("ld_addr_held", fa, 32'h40);
    chk("ld_stall_or_stability", bad, 0);
    chk("ld_rdata", a.d_rdata, 32'hA5A5_0040);
    a.d_req = 0;
    @(posedge clock); #1;
    a.d_req = 1; a.d_we = 1; a.d_addr = 32'h10; a.d_wdata = 32'hDEAD_BEEF;
    wait_done(1, 0, n, en, wen, fa, fw, bad);
    chk("sw_done_cycle", n, 3);
    chk("sw_we_cycles", wen, 2);
    chk("sw_addr", fa, 32'h10);
    chk("sw_wdata", fw, 32'hDEAD_BEEF);
    chk("sw_stall_or_stability", bad, 0);
    chk("sw_rdata_kept", a.d_rdata, 32'hA5A5_0040);
    a.d_req = 0; a.d_we = 0;
    @(posedge clock); #1;
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    a.i_req = 1; a.i_addr = 32'h4; a.d_req = 1; a.d_addr = 32'h20;
    k = 0; t = 0;
    while (k < 4 && t < 60) begin
      @(posedge clock); #1;
      t++;
      if (a.i_done || a.d_done) begin
        own[k] = int'(a.d_done);
        at[k] = t;
        k++;
      end
    end
    chk("alt_done_count", k, 4);
    chk("alt_first_cycle", at[0], 3);
    for (int i = 0; i < k; i++) chk("alt_owner", own[i], (i % 2 == 0) ? 1 : 0);
    for (int i = 1; i < k; i++) chk("alt_spacing", at[i] - at[i-1], L + 2);
    a.i_req = 0; a.d_req = 0;
    @(posedge clock); #1;
    a.d_req = 1; a.d_we = 0; a.d_addr = 32'h40;
    @(posedge clock); #1;
    chkb("rst_in_busy", a.mem_en, 1'b1);
    reset = 1; a.i_req = 1;
    @(posedge clock); #1;
    chkb("rst_mem_en", a.mem_en, 1'b0);
    chkb("rst_mem_we", a.mem_we, 1'b0);
    chk("rst_addr", a.mem_addr, 32'h0);
    chk("rst_wdata", a.mem_wdata, 32'h0);
    chkb("rst_i_done", a.i_done, 1'b0);
    chkb("rst_d_done", a.d_done, 1'b0);
    chk("rst_i_rdata", a.i_rdata, 32'h0);
    chk("rst_d_rdata", a.d_rdata, 32'h0);
    reset = 0;
    t = 0;
    while (!(a.i_done || a.d_done) && t < 40) begin
      @(posedge clock); #1;
      t++;
    end
    chk("rst_first_done_cycle", t, 3);
    chkb("rst_first_grant_d", a.d_done, 1'b1);
    chkb("rst_first_not_i", a.i_done, 1'b0);
    a.i_req = 0; a.d_req = 0;
    @(posedge clock); #1;
    b.d_req = 1; b.d_we = 0; b.d_addr = 32'h20;
    n = 0; en = 0;
    while (!b.d_done && n < 20) begin
      @(posedge clock); #1;
      n++;
      if (b.mem_en) en++;
    end
    chk("lat1_done_cycle", n, 2);
    chk("lat1_busy_cycles", en, 1);
    chk("lat1_rdata", b.d_rdata, 32'h1234_5678);
    b.d_req = 0;
    i_fin = 0; d_fin = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clock); #1;
      if (i_fin) begin
        i_fin = 0;
        a.i_req = $urandom_range(0, 3) != 0;
        a.i_addr = rnd_addr();
      end else if (!a.i_req && $urandom_range(0, 2) == 0) begin
        a.i_req = 1;
        a.i_addr = rnd_addr();
      end
      if (d_fin) begin
        d_fin = 0;
        a.d_req = $urandom_range(0, 3) != 0;
        a.d_we = 1'($urandom_range(0, 1));
        a.d_addr = rnd_addr();
        a.d_wdata = $urandom;
      end else if (!a.d_req && $urandom_range(0, 2) == 0) begin
        a.d_req = 1;
        a.d_we = 1'($urandom_range(0, 1));
        a.d_addr = rnd_addr();
        a.d_wdata = $urandom;
      end
      if (a.i_done) i_fin = 1;
      if (a.d_done) d_fin = 1;
    end
    if (i_fin) a.i_req = 0;
    if (d_fin) a.d_req = 0;
    for (int c = 0; c < 40 && (a.i_req || a.d_req); c++) begin
      @(posedge clock); #1;
      if (a.i_done) a.i_req = 0;
      if (a.d_done) a.d_req = 0;
    end
    chkb("drain_complete", a.i_req | a.d_req, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
